fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction queue between fetch and decode. Accepts up to two instructions per cycle from fetch and stores them in a circular FIFO. Presents the oldest one or two entries to decode as a pair, using decode's ready/valid handshake. Absorbs fetch/decode rate mismatch and the partial fetch groups caused by branch targets, and discards all contents on pipeline flush.

## Interface
Parameters:
- DEPTH, 8, number of instruction entries; power of two, minimum 4.
- CPU_ADDR_BITS, from uarch_pkg, PC width.
- CPU_INST_BITS, from uarch_pkg, instruction width (32).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- fb_rdy  out  1  buffer can accept a full fetch group.
- fetch_pc0, fetch_pc1  in  CPU_ADDR_BITS  PCs of slot 0 and slot 1.
- fetch_inst0, fetch_inst1  in  CPU_INST_BITS  instruction words.
- fetch_val  in  2  per-slot valid. Legal encodings are 00, 01 and 11; 10 is treated as 00.
- decode_rdy  in  1  decode accepts the presented pair.
- inst0_pc, inst1_pc  out  CPU_ADDR_BITS  PCs of the presented pair.
- inst0, inst1  out  CPU_INST_BITS  presented instruction words.
- inst_val  out  1  presented pair is valid.
- fb_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Storage**: DEPTH entries of {pc, inst}, plus head pointer, tail pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Push enable**: fb_rdy = (DEPTH - count) >= 2, computed from registered count only. Same-cycle pops do not raise fb_rdy.
- **Push size**: push_n = 0 when fb_rdy is low. Otherwise push_n = 1 for fetch_val=01 and 2 for fetch_val=11.
- **Push order**: slot 0 is written at tail, slot 1 at tail+1.
- **Presentation**: combinational show-ahead from head.
  - inst0 and inst0_pc come from entry[head].
  - inst1 and inst1_pc come from entry[head+1] when count >= 2.
  - When count < 2, inst1 = 32'h0 and inst1_pc = 0. Decode flags an all-zero word invalid, so a lone instruction issues without waiting for a partner.
- **inst_val** = (count != 0).
- **Pop**: when inst_val and decode_rdy are both high, pop_n = min(count, 2). Otherwise pop_n = 0.
- **Pointer update**: head += pop_n, tail += push_n, count += push_n - pop_n. Push and pop may occur in the same cycle.
- **Flush**:
  - At the next edge, head, tail and count return to 0.
  - Any push or pop in the flush cycle is discarded.
  - Entry contents are don't-care.
- **Reset**: when rst_n falls, head, tail and count clear to 0 immediately, without waiting for an edge. Entry contents are don't-care.
- **Invariants**:
  - Bench-checked: count never exceeds DEPTH.
  - Underflow cannot occur by construction, since pop_n <= count.

## Timing
- **Reset values**:
  - fb_rdy=1, inst_val=0, fb_count=0.
  - inst0, inst1, inst0_pc and inst1_pc are 0 while empty; outputs are forced to 0 whenever count=0.
- **Latency**: an instruction pushed at edge N is visible on the outputs after edge N, in cycle N+1. There is no empty-buffer bypass.
- **Handshake**: a transfer to decode occurs on a cycle where inst_val && decode_rdy. Outputs are held stable while decode_rdy is low.
- **Full boundary**: fb_rdy deasserts at count >= DEPTH-1. At count=DEPTH-1 a single push is also refused.
- **Wrap-around**: a pair straddling entry DEPTH-1 and entry 0 is presented and popped correctly.
- **Simultaneous events**:
  - Push and pop in one cycle are both honoured.
  - flush has priority over push and pop.
  - rst_n has priority over everything.
- **Flush response**: inst_val is low in the cycle after flush. fb_rdy is high in that cycle.

## Test plan
- **Reset**:
  - Stimulus: rst_n low mid-operation with count=5.
  - Required: fb_count=0 and inst_val=0 before the next clk edge; fb_rdy=1.
- **Single and pair flow**:
  - Stimulus: push 11 with pc 0x100/0x104 while decode_rdy=1.
  - Required: next cycle inst_val=1 with inst0_pc=0x100, inst1_pc=0x104; popped that cycle, then fb_count=0.
  - Stimulus: push 01 with pc 0x200.
  - Required: inst1=32'h0 presented, popped alone.
- **Fill and backpressure**:
  - Stimulus: decode_rdy=0, DEPTH=8, push 11 four times.
  - Required: fb_count=8, fb_rdy=0.
  - Stimulus: a further push.
  - Required: ignored, with contents unchanged.
  - Stimulus: at count=7, push 01.
  - Required: refused.
- **Wrap-around ordering**:
  - Stimulus: random decode_rdy over 200 cycles with streamed sequential PCs.
  - Required: output PC sequence strictly in push order, no duplicates or drops, across at least 3 pointer wraps.
- **Simultaneous push/pop**:
  - Stimulus: count=3, push 11 and pop in the same cycle.
  - Required: next fb_count=3; presented pair advances by two.
- **Flush**:
  - Stimulus: count=6, flush=1 together with push 11 and decode_rdy=1.
  - Required: next cycle fb_count=0, inst_val=0.
  - Stimulus: the next push of pc 0x300.
  - Required: 0x300 is the first instruction presented.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst} entries,
// up to two pushes and two pops per cycle, show-ahead pair presentation, flushable.
package uarch_pkg;
  parameter int CPU_ADDR_BITS = 32;
  parameter int CPU_INST_BITS = 32;
endpackage

module fetch_buffer #(
  parameter int DEPTH         = 8,
  parameter int CPU_ADDR_BITS = uarch_pkg::CPU_ADDR_BITS,
  parameter int CPU_INST_BITS = uarch_pkg::CPU_INST_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  output logic                       fb_rdy,
  input  logic [CPU_ADDR_BITS-1:0]   fetch_pc0,
  input  logic [CPU_ADDR_BITS-1:0]   fetch_pc1,
  input  logic [CPU_INST_BITS-1:0]   fetch_inst0,
  input  logic [CPU_INST_BITS-1:0]   fetch_inst1,
  input  logic [1:0]                 fetch_val,
  input  logic                       decode_rdy,
  output logic [CPU_ADDR_BITS-1:0]   inst0_pc,
  output logic [CPU_ADDR_BITS-1:0]   inst1_pc,
  output logic [CPU_INST_BITS-1:0]   inst0,
  output logic [CPU_INST_BITS-1:0]   inst1,
  output logic                       inst_val,
  output logic [$clog2(DEPTH):0]     fb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a pair transfers to decode on any cycle with inst_val && decode_rdy;
  // the presented pair is held stable while decode_rdy is low. Fetch may push only
  // while fb_rdy is high; pushes offered while it is low are dropped.

  logic [CPU_ADDR_BITS-1:0] pc_mem   [DEPTH];
  logic [CPU_INST_BITS-1:0] inst_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          has_pair;

  assign head_p1  = head + PW'(1);
  assign tail_p1  = tail + PW'(1);
  assign has_pair = (count >= CW'(2));

  // Room for a whole group is judged on registered count only, so a
  // same-cycle pop never lets a push in.
  assign fb_rdy   = (count <= CW'(DEPTH - 2));
  assign inst_val = (count != '0);
  assign fb_count = count;

  always_comb begin
    push_n = 2'd0;
    if (fb_rdy) begin
      case (fetch_val)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
  end

  always_comb begin
    pop_n = 2'd0;
    if (inst_val && decode_rdy) begin
      pop_n = has_pair ? 2'd2 : 2'd1;
    end
  end

  // Entry storage needs no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_n != 2'd0) begin
        pc_mem[tail]   <= fetch_pc0;
        inst_mem[tail] <= fetch_inst0;
      end
      if (push_n == 2'd2) begin
        pc_mem[tail_p1]   <= fetch_pc1;
        inst_mem[tail_p1] <= fetch_inst1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Slot 1 reads as all-zero when only one entry is held, letting decode
  // issue a lone instruction without waiting for a partner.
  always_comb begin
    inst0_pc = '0;
    inst0    = '0;
    inst1_pc = '0;
    inst1    = '0;
    if (inst_val) begin
      inst0_pc = pc_mem[head];
      inst0    = inst_mem[head];
    end
    if (has_pair) begin
      inst1_pc = pc_mem[head_p1];
      inst1    = inst_mem[head_p1];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue scoreboard of pushed PCs compared
// against the presented pair every cycle, plus directed boundary scenarios.
module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int IW    = 32;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          fb_rdy;
  logic [AW-1:0] fetch_pc0;
  logic [AW-1:0] fetch_pc1;
  logic [IW-1:0] fetch_inst0;
  logic [IW-1:0] fetch_inst1;
  logic [1:0]    fetch_val;
  logic          decode_rdy;
  logic [AW-1:0] inst0_pc;
  logic [AW-1:0] inst1_pc;
  logic [IW-1:0] inst0;
  logic [IW-1:0] inst1;
  logic          inst_val;
  logic [$clog2(DEPTH):0] fb_count;

  fetch_buffer #(.DEPTH(DEPTH), .CPU_ADDR_BITS(AW), .CPU_INST_BITS(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fb_rdy     (fb_rdy),
    .fetch_pc0  (fetch_pc0),
    .fetch_pc1  (fetch_pc1),
    .fetch_inst0(fetch_inst0),
    .fetch_inst1(fetch_inst1),
    .fetch_val  (fetch_val),
    .decode_rdy (decode_rdy),
    .inst0_pc   (inst0_pc),
    .inst1_pc   (inst1_pc),
    .inst0      (inst0),
    .inst1      (inst1),
    .inst_val   (inst_val),
    .fb_count   (fb_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] next_pc;

  function automatic logic [IW-1:0] mk_inst(input logic [AW-1:0] pc);
    return (pc * 32'd3) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the scoreboard contents.
  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("fb_count", 64'(fb_count), 64'(sz));
    check("count_le_depth", 64'(fb_count <= DEPTH), 64'(1));
    check("inst_val", 64'(inst_val), 64'(sz != 0));
    check("fb_rdy", 64'(fb_rdy), 64'(sz <= DEPTH - 2));
    check("inst0_pc", 64'(inst0_pc), 64'((sz >= 1) ? exp_q[0] : '0));
    check("inst0", 64'(inst0), 64'((sz >= 1) ? mk_inst(exp_q[0]) : '0));
    check("inst1_pc", 64'(inst1_pc), 64'((sz >= 2) ? exp_q[1] : '0));
    check("inst1", 64'(inst1), 64'((sz >= 2) ? mk_inst(exp_q[1]) : '0));
  endtask

  // driver: one cycle of stimulus, with scoreboard update for that edge
  task automatic step(input logic [1:0] fv, input logic [AW-1:0] pc0,
                      input logic [AW-1:0] pc1, input logic rdy, input logic fl);
    int sz;
    int npop;
    check_outputs();
    fetch_val   = fv;
    fetch_pc0   = pc0;
    fetch_pc1   = pc1;
    fetch_inst0 = mk_inst(pc0);
    fetch_inst1 = mk_inst(pc1);
    decode_rdy  = rdy;
    flush       = fl;
    sz = exp_q.size();
    if (fl) begin
      exp_q.delete();
    end else begin
      npop = (rdy && sz > 0) ? ((sz >= 2) ? 2 : 1) : 0;
      for (int i = 0; i < npop; i++) void'(exp_q.pop_front());
      if (sz <= DEPTH - 2) begin
        if (fv == 2'b01 || fv == 2'b11) exp_q.push_back(pc0);
        if (fv == 2'b11) exp_q.push_back(pc1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(2'b00, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(2'b00, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fetch_val = 2'b00; decode_rdy = 1'b0;
    fetch_pc0 = '0; fetch_pc1 = '0; fetch_inst0 = '0; fetch_inst1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    idle();

    // pair flow then lone instruction
    step(2'b11, 32'h100, 32'h104, 1'b1, 1'b0);
    step(2'b00, '0, '0, 1'b1, 1'b0);
    step(2'b01, 32'h200, '0, 1'b1, 1'b0);
    step(2'b00, '0, '0, 1'b1, 1'b0);
    idle();

    // fill to DEPTH with backpressure, then an extra push is ignored
    for (int i = 0; i < 4; i++)
      step(2'b11, 32'h400 + 32'(i * 8), 32'h404 + 32'(i * 8), 1'b0, 1'b0);
    step(2'b11, 32'h500, 32'h504, 1'b0, 1'b0);
    step(2'b01, 32'h510, '0, 1'b0, 1'b0);
    idle();
    do_flush();

    // count = 7: a single push is refused
    for (int i = 0; i < 3; i++)
      step(2'b11, 32'h600 + 32'(i * 8), 32'h604 + 32'(i * 8), 1'b0, 1'b0);
    step(2'b01, 32'h620, '0, 1'b0, 1'b0);
    step(2'b01, 32'h630, '0, 1'b0, 1'b0);
    step(2'b10, 32'h640, 32'h644, 1'b0, 1'b0);
    idle();
    do_flush();

    // simultaneous push/pop at count 3
    step(2'b11, 32'h700, 32'h704, 1'b0, 1'b0);
    step(2'b01, 32'h708, '0, 1'b0, 1'b0);
    step(2'b11, 32'h70c, 32'h710, 1'b1, 1'b0);
    idle();

    // flush at count 6 beats push and pop
    step(2'b11, 32'h714, 32'h718, 1'b0, 1'b0);
    step(2'b01, 32'h71c, '0, 1'b0, 1'b0);
    step(2'b11, 32'h720, 32'h724, 1'b1, 1'b1);
    step(2'b01, 32'h300, '0, 1'b0, 1'b0);
    check("post_flush_first_pc", 64'(inst0_pc), 64'h300);
    step(2'b00, '0, '0, 1'b1, 1'b0);
    idle();

    // random streaming with sequential PCs
    next_pc = 32'h1000;
    for (int c = 0; c < 200; c++) begin
      logic [1:0] fv;
      logic       rdy;
      logic       acc;
      fv  = 2'($urandom_range(0, 3));
      rdy = 1'($urandom_range(0, 1));
      acc = (exp_q.size() <= DEPTH - 2);
      step(fv, next_pc, next_pc + 32'd4, rdy, 1'b0);
      if (acc && fv == 2'b01) next_pc = next_pc + 32'd4;
      if (acc && fv == 2'b11) next_pc = next_pc + 32'd8;
    end
    check("stream_wraps", 64'(next_pc >= 32'h1000 + 32'd4 * 32'(3 * DEPTH)), 64'(1));

    // asynchronous reset mid-operation at count 5
    do_flush();
    step(2'b11, 32'h800, 32'h804, 1'b0, 1'b0);
    step(2'b11, 32'h808, 32'h80c, 1'b0, 1'b0);
    step(2'b01, 32'h810, '0, 1'b0, 1'b0);
    check_outputs();
    fetch_val = 2'b00;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(fb_count), 64'(0));
    check("async_rst_val", 64'(inst_val), 64'(0));
    check("async_rst_rdy", 64'(fb_rdy), 64'(1));
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();
    step(2'b01, 32'h900, '0, 1'b1, 1'b0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
